// File: rtl/aq_axis_pkt_arb_pkg.sv
// aq_axis_pkg: shared types and helpers for the packet arbiter.
//   aq_arb_state_t : arbiter FSM encoding (IDLE, XFER)
//   AQ_ARB_STAT_W  : width of the optional per-source packet counters
//   aq_clog2       : ceil(log2(v)), used to size source index fields
package aq_axis_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      XFER = 1'b1
   } aq_arb_state_t;

   localparam int unsigned AQ_ARB_STAT_W = 16;

   function automatic int unsigned aq_clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/aq_axis_pkt_arb_if.sv
// aq_axis_pkt_arb_if: bundles the NUM_SRC AXI-Stream source ports and the
// FIFO write port that the packet arbiter sits between.
//   S_AXIS_TVALID/TREADY/TLAST : per-source handshake, one bit per source
//   S_AXIS_TDATA               : source i at [i*FIFO_WIDTH +: FIFO_WIDTH]
//   FIFO_WR_ENA/DATA/LAST      : write strobe, data and end-of-packet to FIFO
//   FIFO_WR_FULL/ALM_FULL      : FIFO status back to the arbiter
// modport master : arbiter view; modport slave : sources + FIFO view.
interface aq_axis_pkt_arb_if #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned FIFO_WIDTH = 32
);
   logic [NUM_SRC-1:0]            S_AXIS_TVALID;
   logic [NUM_SRC-1:0]            S_AXIS_TREADY;
   logic [NUM_SRC-1:0]            S_AXIS_TLAST;
   logic [NUM_SRC*FIFO_WIDTH-1:0] S_AXIS_TDATA;
   logic                          FIFO_WR_ENA;
   logic [FIFO_WIDTH-1:0]         FIFO_WR_DATA;
   logic                          FIFO_WR_LAST;
   logic                          FIFO_WR_FULL;
   logic                          FIFO_WR_ALM_FULL;

   modport master (
      input  S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TDATA,
      input  FIFO_WR_FULL, FIFO_WR_ALM_FULL,
      output S_AXIS_TREADY, FIFO_WR_ENA, FIFO_WR_DATA, FIFO_WR_LAST
   );

   modport slave (
      output S_AXIS_TVALID, S_AXIS_TLAST, S_AXIS_TDATA,
      output FIFO_WR_FULL, FIFO_WR_ALM_FULL,
      input  S_AXIS_TREADY, FIFO_WR_ENA, FIFO_WR_DATA, FIFO_WR_LAST
   );
endinterface

// File: rtl/aq_axis_pkt_arb_rr_pick.sv
// aq_rr_pick: combinational round-robin selector.
//   req_i      : request vector, one bit per source
//   last_i     : index of the most recently granted source
//   pick_o     : one-hot winner, first requester searching from last_i+1
//   pick_idx_o : binary index of the winner
//   found_o    : at least one request present
module aq_rr_pick import aq_axis_pkg::*; #(
   parameter int unsigned NUM_SRC = 4,
   parameter int unsigned IDX_W   = aq_clog2(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_SRC-1:0] pick_o,
   output logic [IDX_W-1:0]   pick_idx_o,
   output logic               found_o
);

   int unsigned idx;

   always_comb begin
      pick_o     = '0;
      pick_idx_o = '0;
      found_o    = 1'b0;
      idx        = 0;
      for (int unsigned off = 1; off <= NUM_SRC; off++) begin
         idx = (32'(last_i) + off) % NUM_SRC;
         if (!found_o && req_i[idx]) begin
            found_o      = 1'b1;
            pick_o[idx]  = 1'b1;
            pick_idx_o   = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/aq_axis_pkt_arb.sv
// aq_axis_pkt_arb: packet-level round-robin arbiter in front of a FIFO
// write port. A source is granted for a whole packet (first beat to TLAST)
// so packets never interleave; new grants are withheld while the FIFO is
// almost full, and beats in flight stall only on FIFO full.
//   CLK, RST_N    : single clock, asynchronous active-low reset
//   bus (master)  : source AXI-Stream ports and FIFO write port
//   GRANT         : one-hot current grant, zero when idle
//   BUSY          : a packet is in progress
//   STAT_PKT_CNT  : per-source 16-bit packet counters, only when the
//                   macro AQ_AXIS_ARB_STATS_EN is defined
module aq_axis_pkt_arb import aq_axis_pkg::*; #(
   parameter int unsigned NUM_SRC    = 4,
   parameter int unsigned FIFO_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   aq_axis_pkt_arb_if.master    bus,
   output logic [NUM_SRC-1:0]   GRANT,
   output logic                 BUSY
`ifdef AQ_AXIS_ARB_STATS_EN
   ,
   output logic [NUM_SRC*AQ_ARB_STAT_W-1:0] STAT_PKT_CNT
`endif
);

   localparam int unsigned IDX_W = aq_clog2(NUM_SRC);

   aq_arb_state_t      state_q, state_d;
   logic [NUM_SRC-1:0] grant_q, grant_d;
   // last_q doubles as the granted index while in XFER
   logic [IDX_W-1:0]   last_q, last_d;

   logic [NUM_SRC-1:0]    pick;
   logic [IDX_W-1:0]      pick_idx;
   logic                  found;

   logic                  sel_valid;
   logic                  sel_last;
   logic [FIFO_WIDTH-1:0] sel_data;

   logic [NUM_SRC-1:0]    tready;
   logic                  wr_ena;
   logic                  wr_last;
   logic [FIFO_WIDTH-1:0] wr_data;

   aq_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req_i      (bus.S_AXIS_TVALID),
      .last_i     (last_q),
      .pick_o     (pick),
      .pick_idx_o (pick_idx),
      .found_o    (found)
   );

   // Source mux for the granted index
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (last_q == IDX_W'(i)) begin
            sel_valid = bus.S_AXIS_TVALID[i];
            sel_last  = bus.S_AXIS_TLAST[i];
            sel_data  = bus.S_AXIS_TDATA[i*FIFO_WIDTH +: FIFO_WIDTH];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      tready  = '0;
      wr_ena  = 1'b0;
      wr_last = 1'b0;
      wr_data = '0;
      case (state_q)
         IDLE: begin
            if (found && !bus.FIFO_WR_ALM_FULL) begin
               grant_d = pick;
               last_d  = pick_idx;
               state_d = XFER;
            end
         end
         XFER: begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
               tready[i] = (last_q == IDX_W'(i)) && !bus.FIFO_WR_FULL;
            end
            wr_ena  = sel_valid && !bus.FIFO_WR_FULL;
            wr_last = sel_last;
            wr_data = sel_data;
            if (wr_ena && sel_last) begin
               grant_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_SRC - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   assign bus.S_AXIS_TREADY = tready;
   assign bus.FIFO_WR_ENA   = wr_ena;
   assign bus.FIFO_WR_LAST  = wr_last;
   assign bus.FIFO_WR_DATA  = wr_data;
   assign GRANT             = grant_q;
   assign BUSY              = (state_q == XFER);

`ifdef AQ_AXIS_ARB_STATS_EN
   logic [AQ_ARB_STAT_W-1:0] cnt_q [NUM_SRC];

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (wr_ena && sel_last && (last_q == IDX_W'(i)))
               cnt_q[i] <= cnt_q[i] + 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_stat
      assign STAT_PKT_CNT[g*AQ_ARB_STAT_W +: AQ_ARB_STAT_W] = cnt_q[g];
   end
`endif

endmodule

// File: tb/tb_aq_axis_pkt_arb.sv
// tb_aq_axis_pkt_arb: directed self-checking bench for aq_axis_pkt_arb
// (NUM_SRC=4, FIFO_WIDTH=32). Sources are scripted per test; every cycle
// the observed {GRANT, TREADY, BUSY, WR_ENA, WR_LAST, WR_DATA} is compared
// with a hand-computed vector. Counter checks run when the macro
// AQ_AXIS_ARB_STATS_EN is defined.
module tb_aq_axis_pkt_arb;
   import aq_axis_pkg::*;

   localparam int unsigned N = 4;
   localparam int unsigned W = 32;

   typedef logic [2*N+3+W-1:0] vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aq_axis_pkt_arb_if #(.NUM_SRC(N), .FIFO_WIDTH(W)) bus ();
   logic [N-1:0] grant;
   logic         busy;
`ifdef AQ_AXIS_ARB_STATS_EN
   logic [N*16-1:0] stat;
`endif

   aq_axis_pkt_arb #(.NUM_SRC(N), .FIFO_WIDTH(W)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus),
      .GRANT (grant),
      .BUSY  (busy)
`ifdef AQ_AXIS_ARB_STATS_EN
      ,
      .STAT_PKT_CNT (stat)
`endif
   );

   int unsigned passed = 0;
   int unsigned total  = 0;

   // scripted source state
   int unsigned src_len  [N];
   int unsigned src_beat [N];
   int unsigned src_left [N];
   logic [W-1:0] src_base [N];
   logic full_v = 1'b0;
   logic alm_v  = 1'b0;

   function automatic vec_t mk(logic [N-1:0] g, logic [N-1:0] r, logic b,
                               logic e, logic l, logic [W-1:0] d);
      return {g, r, b, e, l, d};
   endfunction

   function automatic vec_t obs();
      return {grant, bus.S_AXIS_TREADY, busy, bus.FIFO_WR_ENA,
              bus.FIFO_WR_LAST, bus.FIFO_WR_DATA};
   endfunction

   task automatic clear_src();
      for (int i = 0; i < N; i++) begin
         src_len[i] = 1; src_beat[i] = 0; src_left[i] = 0; src_base[i] = '0;
      end
      full_v = 1'b0;
      alm_v  = 1'b0;
   endtask

   task automatic apply_src();
      for (int i = 0; i < N; i++) begin
         bus.S_AXIS_TVALID[i]       = (src_left[i] != 0);
         bus.S_AXIS_TLAST[i]        = (src_beat[i] == src_len[i] - 1);
         bus.S_AXIS_TDATA[i*W +: W] = src_base[i] + W'(src_beat[i]);
      end
      bus.FIFO_WR_FULL     = full_v;
      bus.FIFO_WR_ALM_FULL = alm_v;
   endtask

   // Advance one clock: record handshakes seen before the edge, update the
   // scripted sources, drive new inputs 1 ns after the edge, settle 1 ns.
   task automatic step();
      logic [N-1:0] acc;
      acc = bus.S_AXIS_TVALID & bus.S_AXIS_TREADY;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            if (src_beat[i] == src_len[i] - 1) begin
               src_beat[i] = 0;
               if (src_left[i] != 0) src_left[i]--;
            end else begin
               src_beat[i]++;
            end
         end
      end
      apply_src();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_src();
      apply_src();
      step();
      step();
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      vec_t o;
      clear_src();
      rst_n = 1'b0;
      src_left[0] = 1;
      apply_src();
      for (int k = 0; k < 2; k++) begin
         step();
         o = obs();
         total++;
         if (o !== mk('0, '0, 0, 0, 0, '0))
            $display("FAIL reset_hold cyc %0d: got %h expected %h", k, o, mk('0, '0, 0, 0, 0, '0));
         else passed++;
      end
   endtask

   task automatic test_back_to_back();
      vec_t o, e;
      logic [N-1:0] oh;
      int unsigned ph, src;
      do_reset();
      for (int i = 0; i < N; i++) begin
         src_len[i]  = 2;
         src_left[i] = (i == 0) ? 2 : 1;
         src_base[i] = 32'hD000_0000 + 32'(i) * 32'h100;
      end
      for (int k = 0; k < 16; k++) begin
         step();
         ph  = k % 3;
         src = (k / 3) % 4;
         oh  = '0;
         oh[src] = 1'b1;
         if (ph == 0) e = mk('0, '0, 0, 0, 0, '0);
         else e = mk(oh, oh, 1, 1, (ph == 2), 32'hD000_0000 + 32'(src) * 32'h100 + 32'(ph - 1));
         o = obs();
         total++;
         if (o !== e) $display("FAIL back_to_back cyc %0d: got %h expected %h", k, o, e);
         else passed++;
      end
   endtask

   task automatic test_no_interleave();
      vec_t o;
      vec_t e [7];
      do_reset();
      e[0] = mk('0, '0, 0, 0, 0, '0);
      e[1] = mk(4'b0100, 4'b0100, 1, 1, 0, 32'hA0);
      e[2] = mk(4'b0100, 4'b0100, 1, 1, 0, 32'hA1);
      e[3] = mk(4'b0100, 4'b0100, 1, 1, 1, 32'hA2);
      e[4] = mk('0, '0, 0, 0, 0, '0);
      e[5] = mk(4'b0010, 4'b0010, 1, 1, 1, 32'hB0);
      e[6] = mk('0, '0, 0, 0, 0, '0);
      src_len[2] = 3; src_left[2] = 1; src_base[2] = 32'hA0;
      for (int k = 0; k < 7; k++) begin
         if (k == 2) begin
            src_len[1] = 1; src_left[1] = 1; src_base[1] = 32'hB0;
         end
         step();
         o = obs();
         total++;
         if (o !== e[k]) $display("FAIL no_interleave cyc %0d: got %h expected %h", k, o, e[k]);
         else passed++;
      end
   endtask

   task automatic test_alm_full();
      vec_t o;
      vec_t e [8];
      do_reset();
      for (int k = 0; k < 4; k++) e[k] = mk('0, '0, 0, 0, 0, '0);
      e[4] = mk(4'b0001, 4'b0001, 1, 1, 0, 32'hC0);
      e[5] = mk(4'b0001, 4'b0001, 1, 1, 1, 32'hC1);
      e[6] = mk('0, '0, 0, 0, 0, '0);
      e[7] = mk('0, '0, 0, 0, 0, '0);
      src_len[0] = 2; src_left[0] = 1; src_base[0] = 32'hC0;
      alm_v = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k == 3) alm_v = 1'b0;
         if (k == 5) alm_v = 1'b1;
         step();
         o = obs();
         total++;
         if (o !== e[k]) $display("FAIL alm_full cyc %0d: got %h expected %h", k, o, e[k]);
         else passed++;
      end
      alm_v = 1'b0;
   endtask

   task automatic test_full_stall();
      vec_t o;
      vec_t e [7];
      do_reset();
      e[0] = mk('0, '0, 0, 0, 0, '0);
      e[1] = mk(4'b1000, 4'b1000, 1, 1, 0, 32'hE0);
      e[2] = mk(4'b1000, 4'b0000, 1, 0, 1, 32'hE1);
      e[3] = e[2];
      e[4] = e[2];
      e[5] = mk(4'b1000, 4'b1000, 1, 1, 1, 32'hE1);
      e[6] = mk('0, '0, 0, 0, 0, '0);
      src_len[3] = 2; src_left[3] = 1; src_base[3] = 32'hE0;
      for (int k = 0; k < 7; k++) begin
         if (k == 2) full_v = 1'b1;
         if (k == 5) full_v = 1'b0;
         step();
         o = obs();
         total++;
         if (o !== e[k]) $display("FAIL full_stall cyc %0d: got %h expected %h", k, o, e[k]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid_packet();
      vec_t o, e;
      do_reset();
      src_len[2] = 4; src_left[2] = 1; src_base[2] = 32'hF0;
      step();
      step();
      step();
      o = obs();
      e = mk(4'b0100, 4'b0100, 1, 1, 0, 32'hF1);
      total++;
      if (o !== e) $display("FAIL rst_mid_beat2: got %h expected %h", o, e);
      else passed++;
      #2 rst_n = 1'b0;
      #1;
      o = obs();
      e = mk('0, '0, 0, 0, 0, '0);
      total++;
      if (o !== e) $display("FAIL rst_mid_async: got %h expected %h", o, e);
      else passed++;
      clear_src();
      apply_src();
      step();
      o = obs();
      total++;
      if (o !== e) $display("FAIL rst_mid_hold: got %h expected %h", o, e);
      else passed++;
      #1 rst_n = 1'b1;
      src_len[0] = 1; src_left[0] = 1; src_base[0] = 32'h55;
      src_len[2] = 4; src_left[2] = 1; src_base[2] = 32'hF0;
      step();
      o = obs();
      total++;
      if (o !== e) $display("FAIL rst_mid_rearb: got %h expected %h", o, e);
      else passed++;
      step();
      o = obs();
      e = mk(4'b0001, 4'b0001, 1, 1, 1, 32'h55);
      total++;
      if (o !== e) $display("FAIL rst_mid_src0_wins: got %h expected %h", o, e);
      else passed++;
   endtask

`ifdef AQ_AXIS_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      total++;
      if (stat !== '0) $display("FAIL stats_reset: got %h expected 0", stat);
      else passed++;
      src_len[3] = 1; src_left[3] = 5; src_base[3] = 32'h30;
      for (int k = 0; k < 12; k++) step();
      total++;
      if (stat !== {16'd5, 16'd0, 16'd0, 16'd0})
         $display("FAIL stats_src3_5pkts: got %h expected %h", stat, {16'd5, 16'd0, 16'd0, 16'd0});
      else passed++;
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_src();
      apply_src();
      test_reset();
      test_back_to_back();
      test_no_interleave();
      test_alm_full();
      test_full_stall();
      test_reset_mid_packet();
`ifdef AQ_AXIS_ARB_STATS_EN
      test_stats();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
